// File: rtl/cr_kme_fifo_unpack.sv
// Unpacks 132-bit KME FIFO entries (up to four 32-bit beats) into a beat stream with sop/eop framing.
// Latency: first beat one cycle after in_ack; backpressure: out_ready=0 freezes the beat and withholds in_ack.
module cr_kme_fifo_unpack #(
  parameter int PKT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [131:0]         in_data,
  input  logic                 in_valid,
  output logic                 in_ack,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  input  logic                 out_ready,
  input  logic                 err_clr,
  output logic                 proto_err,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  typedef enum logic {
    IDLE   = 1'b0,
    UNPACK = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [127:0]   payload;
  logic [1:0]     last_idx;
  logic [1:0]     idx;
  logic           sop_held;
  logic           eop_held;
  logic           in_pkt;
  logic           in_pkt_live;
  logic           load;
  logic           beat_acc;
  logic           last_beat;
  logic           eop_acc;
  logic           new_sop;
  logic           new_eop;
  logic           frame_viol;

  assign new_sop   = in_data[131];
  assign new_eop   = in_data[130];
  assign last_beat = (idx == last_idx);
  assign load      = in_ack;
  assign eop_acc   = beat_acc & out_eop;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = UNPACK;
        end
      end
      UNPACK: begin
        if (beat_acc && last_beat && !load) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: out_* come only from held state; in_ack is the only path from in_*
  always_comb begin
    out_valid = (state == UNPACK);
    beat_acc  = out_valid & out_ready;
    in_ack    = ~rst & in_valid & ((state == IDLE) | (beat_acc & last_beat));
    out_data  = out_valid ? payload[{idx, 5'd0} +: 32] : 32'd0;
    out_sop   = out_valid & sop_held & (idx == 2'd0);
    out_eop   = out_valid & eop_held & last_beat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      payload  <= '0;
      last_idx <= '0;
      idx      <= '0;
      sop_held <= 1'b0;
      eop_held <= 1'b0;
    end else if (load) begin
      payload  <= in_data[127:0];
      last_idx <= in_data[129:128];
      idx      <= '0;
      sop_held <= new_sop;
      eop_held <= new_eop;
    end else if (beat_acc && !last_beat) begin
      idx <= idx + 2'd1;
    end
  end

  // An eop beat accepted in the same cycle as the next load closes the packet first.
  assign in_pkt_live = in_pkt & ~eop_acc;
  assign frame_viol  = load & ((new_sop & in_pkt_live) | (~new_sop & ~in_pkt_live));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_pkt <= 1'b0;
    end else if (load && new_sop && !new_eop) begin
      in_pkt <= 1'b1;
    end else if (eop_acc) begin
      in_pkt <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (frame_viol) begin
      proto_err <= 1'b1;
    end else if (err_clr) begin
      proto_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (eop_acc) begin
      pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cr_kme_fifo_unpack.sv
// Scenario bench for cr_kme_fifo_unpack: a FIFO model feeds entries, a beat scoreboard checks the output stream.
module tb_cr_kme_fifo_unpack;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [131:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ack;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic          out_ready = 1'b0;
  logic          err_clr = 1'b0;
  logic          proto_err;
  logic [CW-1:0] pkt_cnt;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  logic [131:0] src_q[$];
  beat_t        exp_q[$];
  int           errors = 0;
  int           checks = 0;

  cr_kme_fifo_unpack #(.PKT_CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ack    (in_ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .proto_err (proto_err),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [131:0] mk(input logic sop, input logic eop, input logic [1:0] li,
                                      input logic [127:0] pl);
    return {sop, eop, li, pl};
  endfunction

  // One clock: drive inputs at negedge, sample 1ns later, update FIFO model and scoreboard.
  task automatic run_cycle(input logic rdy, input logic clr, output logic acked, output logic beat);
    logic [131:0] e;
    beat_t        b;
    @(negedge clk);
    in_valid  = (src_q.size() != 0);
    in_data   = in_valid ? src_q[0] : '0;
    out_ready = rdy;
    err_clr   = clr;
    #1;
    checks++;
    if (in_ack && !in_valid) begin
      errors++;
      $display("FAIL ack_without_valid: in_ack=%0b required 0", in_ack);
    end
    acked = in_ack & in_valid;
    beat  = out_valid & out_ready;
    if (beat) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data=%h sop=%0b eop=%0b, none expected", out_data, out_sop, out_eop);
      end else begin
        b = exp_q.pop_front();
        if ({out_data, out_sop, out_eop} !== {b.data, b.sop, b.eop}) begin
          errors++;
          $display("FAIL beat: got data=%h sop=%0b eop=%0b, required data=%h sop=%0b eop=%0b",
                   out_data, out_sop, out_eop, b.data, b.sop, b.eop);
        end
      end
    end
    if (acked) begin
      e = src_q.pop_front();
      for (int k = 0; k <= int'(e[129:128]); k++) begin
        b.data = e[k*32 +: 32];
        b.sop  = e[131] && (k == 0);
        b.eop  = e[130] && (k == int'(e[129:128]));
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic drain(input string name);
    logic a, bt;
    int   n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
      run_cycle(1'b1, 1'b0, a, bt);
      n++;
    end
    run_cycle(1'b1, 1'b0, a, bt);
    checks++;
    if (exp_q.size() != 0 || src_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: %0d beats %0d entries left, required 0", name, exp_q.size(), src_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    err_clr = 1'b0;
    src_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = mk(1'b1, 1'b1, 2'd3, {4{32'hA5A5A5A5}});
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({in_ack, out_valid, out_sop, out_eop, out_data, proto_err, pkt_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%0b vld=%0b sop=%0b eop=%0b data=%h err=%0b cnt=%0d, required all 0",
               in_ack, out_valid, out_sop, out_eop, out_data, proto_err, pkt_cnt);
    end
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic a, bt;
    int   ack_c = -1, first = -1, last = -1, nb = 0;
    src_q.push_back(mk(1'b1, 1'b1, 2'd3,
                       {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}));
    for (int c = 0; c < 6; c++) begin
      run_cycle(1'b1, 1'b0, a, bt);
      if (a && ack_c < 0) ack_c = c;
      if (bt) begin
        if (first < 0) first = c;
        last = c;
        nb++;
      end
    end
    checks++;
    if (ack_c !== 0) begin
      errors++;
      $display("FAIL single_ack_cycle: got %0d required 0", ack_c);
    end
    checks++;
    if ({first, last, nb} !== {32'sd1, 32'sd4, 32'sd4}) begin
      errors++;
      $display("FAIL single_beats: first=%0d last=%0d n=%0d required 1 4 4", first, last, nb);
    end
    checks++;
    if (pkt_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL single_pkt_cnt: got %0d required 1", pkt_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic          a, bt;
    int            acks[$];
    int            first = -1, last = -1, nb = 0;
    logic [CW-1:0] cnt0 = pkt_cnt;
    src_q.push_back(mk(1'b1, 1'b0, 2'd3, {32'hA3, 32'hA2, 32'hA1, 32'hA0}));
    src_q.push_back(mk(1'b0, 1'b1, 2'd3, {32'hB3, 32'hB2, 32'hB1, 32'hB0}));
    for (int c = 0; c < 10; c++) begin
      run_cycle(1'b1, 1'b0, a, bt);
      if (a) acks.push_back(c);
      if (bt) begin
        if (first < 0) first = c;
        last = c;
        nb++;
      end
    end
    checks++;
    if (acks.size() != 2 || acks[0] != 0 || acks[1] != 4) begin
      errors++;
      $display("FAIL b2b_ack_cycles: got %0d acks (second at %0d) required acks at 0 and 4",
               acks.size(), (acks.size() > 1) ? acks[1] : -1);
    end
    checks++;
    if ({first, last, nb} !== {32'sd1, 32'sd8, 32'sd8}) begin
      errors++;
      $display("FAIL b2b_no_gap: first=%0d last=%0d n=%0d required 1 8 8", first, last, nb);
    end
    checks++;
    if (pkt_cnt !== CW'(cnt0 + 1) || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_cnt_err: cnt=%0d err=%0b required cnt=%0d err=0", pkt_cnt, proto_err, CW'(cnt0 + 1));
    end
  endtask

  task automatic test_stall();
    logic        a, bt;
    logic [31:0] d_hold;
    logic [1:0]  fl_hold;
    int          nb = 0;
    src_q.push_back(mk(1'b1, 1'b1, 2'd1, {32'h0, 32'h0, 32'hCAFE0002, 32'hCAFE0001}));
    run_cycle(1'b0, 1'b0, a, bt);
    for (int r = 0; r < 2; r++) begin
      run_cycle(1'b0, 1'b0, a, bt);
      d_hold  = out_data;
      fl_hold = {out_sop, out_eop};
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_valid_%0d: got %0b required 1", r, out_valid);
      end
      run_cycle(1'b1, 1'b0, a, bt);
      if (bt) nb++;
      checks++;
      if (out_data !== d_hold || {out_sop, out_eop} !== fl_hold) begin
        errors++;
        $display("FAIL stall_hold_%0d: data=%h flags=%b required data=%h flags=%b",
                 r, out_data, {out_sop, out_eop}, d_hold, fl_hold);
      end
    end
    repeat (3) begin
      run_cycle(1'b1, 1'b0, a, bt);
      if (bt) nb++;
    end
    checks++;
    if (nb !== 2) begin
      errors++;
      $display("FAIL stall_beat_count: got %0d required 2", nb);
    end
  endtask

  task automatic test_proto();
    logic a, bt;
    do_reset();
    src_q.push_back(mk(1'b0, 1'b1, 2'd0, {96'h0, 32'hDEAD0001}));
    run_cycle(1'b1, 1'b0, a, bt);
    checks++;
    if (a !== 1'b1 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_ack_cycle: ack=%0b err=%0b required ack=1 err=0", a, proto_err);
    end
    run_cycle(1'b1, 1'b0, a, bt);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_set: got %0b required 1", proto_err);
    end
    run_cycle(1'b1, 1'b1, a, bt);
    run_cycle(1'b1, 1'b0, a, bt);
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_clear: got %0b required 0", proto_err);
    end
    src_q.push_back(mk(1'b0, 1'b0, 2'd0, {96'h0, 32'hDEAD0002}));
    run_cycle(1'b1, 1'b1, a, bt);
    run_cycle(1'b1, 1'b0, a, bt);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_set_wins: got %0b required 1", proto_err);
    end
    drain("proto");
  endtask

  task automatic test_reset_mid();
    logic a, bt;
    int   nb = 0;
    do_reset();
    src_q.push_back(mk(1'b1, 1'b1, 2'd3, {32'h4, 32'h3, 32'h2, 32'h1}));
    repeat (3) run_cycle(1'b1, 1'b0, a, bt);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ack !== 1'b0 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL midreset_outputs: vld=%0b ack=%0b data=%h required 0 0 0", out_valid, in_ack, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (4) begin
      run_cycle(1'b1, 1'b0, a, bt);
      if (bt) nb++;
    end
    checks++;
    if (nb !== 0 || pkt_cnt !== '0) begin
      errors++;
      $display("FAIL midreset_discard: beats=%0d cnt=%0d required 0 0", nb, pkt_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      src_q.push_back(mk(1'b1, 1'b1, 2'd0, {96'h0, 32'(i)}));
    end
    drain("wrap_fill");
    checks++;
    if (pkt_cnt !== {CW{1'b1}}) begin
      errors++;
      $display("FAIL cnt_max: got %0d required %0d", pkt_cnt, (1 << CW) - 1);
    end
    src_q.push_back(mk(1'b1, 1'b1, 2'd2, {32'h0, 32'h77, 32'h66, 32'h55}));
    drain("wrap_last");
    checks++;
    if (pkt_cnt !== '0) begin
      errors++;
      $display("FAIL cnt_wrap: got %0d required 0", pkt_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_proto();
    test_reset_mid();
    test_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
